// File: rtl/eager_fork_pkg.sv
`default_nettype none
// ============================================================================
// eager_fork_pkg : shared handshake constants and branch-slicing helper
// Rev 1.0
// ============================================================================
package eager_fork_pkg;

  localparam int DATA_TYPE_DEFAULT = 32;
  localparam int MAX_SIZE          = 16;
  localparam int MAX_BUS_W         = MAX_SIZE * DATA_TYPE_DEFAULT;

  // Extracts branch idx from a flattened bus (zero-extend narrower buses).
  function automatic logic [DATA_TYPE_DEFAULT-1:0] branch_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          idx
  );
    return bus[idx*DATA_TYPE_DEFAULT +: DATA_TYPE_DEFAULT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/eager_fork_if.sv
`default_nettype none
// ============================================================================
// eager_fork_if : one-in / SIZE-out valid-ready token bundle
// Rev 1.0
// ============================================================================
interface eager_fork_if
  import eager_fork_pkg::*;
#(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = DATA_TYPE_DEFAULT
) ();

  logic [DATA_TYPE-1:0]      ins;
  logic                      ins_valid;
  logic                      ins_ready;
  logic [SIZE*DATA_TYPE-1:0] outs;
  logic [SIZE-1:0]           outs_valid;
  logic [SIZE-1:0]           outs_ready;

  // master: the fork itself; slave: the surrounding producer/consumers.
  modport master (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );

  modport slave (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

endinterface
`default_nettype wire

// File: rtl/eager_fork_branch.sv
`default_nettype none
// ============================================================================
// eager_fork_branch : one output branch of the eager fork (single sent flag)
// Rev 1.0
// ============================================================================
module eager_fork_branch (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic outs_ready_i,
  input  logic all_done,
  output logic outs_valid_i,
  output logic done_i
);

  logic sent;

  // Completion wins over a same-cycle acceptance so the next token starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent <= 1'b0;
    end else if (ins_valid && all_done) begin
      sent <= 1'b0;
    end else if (outs_valid_i && outs_ready_i) begin
      sent <= 1'b1;
    end
  end

  assign outs_valid_i = ~rst & ins_valid & ~sent;
  assign done_i       = sent | outs_ready_i;

endmodule
`default_nettype wire

// File: rtl/eager_fork.sv
`default_nettype none
// ============================================================================
// eager_fork : delivers one token to SIZE consumers, each accepting on its own
// Config macro FORK_LAZY_EN: lazy fork with no per-branch state.  Rev 1.0
// ============================================================================
module eager_fork
  import eager_fork_pkg::*;
#(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = DATA_TYPE_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  eager_fork_if.master bus
);

  logic [SIZE-1:0] done;

  for (genvar i = 0; i < SIZE; i++) begin : g_rep
    assign bus.outs[i*DATA_TYPE +: DATA_TYPE] = bus.ins;
  end

`ifdef FORK_LAZY_EN
  // A branch is offered the token only when every other branch can take it too.
  for (genvar i = 0; i < SIZE; i++) begin : g_lazy
    localparam logic [SIZE-1:0] SELF = SIZE'(1) << i;
    assign bus.outs_valid[i] = ~rst & bus.ins_valid & (&(bus.outs_ready | SELF));
  end

  assign done = bus.outs_ready;
`else
  logic all_done;

  assign all_done = &done;

  for (genvar i = 0; i < SIZE; i++) begin : g_branch
    eager_fork_branch u_branch (
      .clk          (clk),
      .rst          (rst),
      .ins_valid    (bus.ins_valid),
      .outs_ready_i (bus.outs_ready[i]),
      .all_done     (all_done),
      .outs_valid_i (bus.outs_valid[i]),
      .done_i       (done[i])
    );
  end
`endif

  assign bus.ins_ready = ~rst & (&done);

endmodule
`default_nettype wire

// File: doc/eager_fork.md
Name: eager_fork

Overview:
- Elastic-circuit eager fork. It is the producer-side counterpart of the N-input join that arithmetic wrappers use.
- Takes one valid/ready token with DATA_TYPE-bit payload and delivers it to SIZE consumers independently. Each consumer may accept in a different cycle.
- Upstream is released only after every consumer has taken the token.
- Sits after any operator result (e.g. divf/mulf output) whose value feeds several downstream units.

Parameters:
- SIZE, 2, number of output branches (>=1).
- DATA_TYPE, 32, payload width in bits (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- ins  input  DATA_TYPE  input payload.
- ins_valid  input  1  upstream token valid.
- ins_ready  output  1  token consumed by all branches this cycle.
- outs  output  SIZE*DATA_TYPE  payload replicated per branch; branch i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- outs_valid  output  SIZE  per-branch valid.
- outs_ready  input  SIZE  per-branch ready.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State: sent[SIZE-1:0], one flag per branch. sent[i]=1 means branch i already accepted the current token.
- Reset: sent <= 0 at the first clk edge with rst=1. While rst=1, outs_valid=0 and ins_ready=0, regardless of inputs.
- Combinational outputs when rst=0:
  - outs_valid[i] = ins_valid & ~sent[i].
  - done[i] = sent[i] | outs_ready[i].
  - ins_ready = &done. This is independent of ins_valid; ready may be asserted without valid.
  - outs[i] = ins. Zero latency, no data register.
- Next state:
  - If ins_valid & ins_ready: sent <= 0 (token complete, all branches fresh for the next token).
  - Else: sent[i] <= sent[i] | (outs_valid[i] & outs_ready[i]).
- Latency: 0 cycles when all outs_ready are high. Otherwise the token completes in the cycle the last pending branch asserts ready.
- Throughput: one token per cycle when all consumers are ready.
- No combinational path from outs_ready[j] to outs_valid[i].
- Simultaneous events: branches accepting in the same cycle as completion leave sent cleared, never set.
- Upstream must hold ins_valid and ins stable until ins_ready. Dropping ins_valid mid-token is a protocol violation. Required behaviour in that case: sent flags hold their value and are not cleared.
- Reset mid-token: all sent flags clear. The partially delivered token is re-offered to every branch after reset releases.
- SIZE=1: degenerates to a wire. outs_valid=ins_valid, ins_ready=outs_ready; sent stays 0.

Optional Feature:
- Macro: FORK_LAZY_EN.
- Defined: lazy fork, no sent registers.
  - outs_valid[i] = ins_valid & (AND of outs_ready[j] for j!=i).
  - ins_ready = &outs_ready.
  - rst gating of outputs is kept.
- Undefined: eager behaviour as above.
- The port list is identical in both builds.

Decomposition:
- The shared handshake package holds:
  - the DATA_TYPE default constant;
  - a function that slices branch i out of a flattened SIZE*DATA_TYPE bus (used by benches and parent modules).
- One sub-module: eager_fork_branch, instantiated SIZE times. It holds a single sent flag.
  - Inputs: clk, rst, ins_valid, outs_ready_i, all_done.
  - Outputs: outs_valid_i, done_i.
- The top level does the AND-reduction and data replication.

Test Plan:
- Reset: SIZE=3, ins_valid=1 with rst=1 -> outs_valid=3'b000, ins_ready=0. After rst=0 -> outs_valid=3'b111, sent=0.
- Full throughput: SIZE=3, outs_ready=3'b111, ins 0x3F800000,0x40000000,0x40400000 on consecutive cycles -> each appears on all three branches the same cycle; ins_ready=1 every cycle.
- Staggered acceptance: ins=0xDEADBEEF held.
  - Cycle0 outs_ready=001 -> outs_valid=111, ins_ready=0.
  - Cycle1 ready=100 -> outs_valid=110.
  - Cycle2 ready=010 -> outs_valid=010, ins_ready=1.
  - Cycle3 -> sent=000.
- Early ready: outs_ready=111 with ins_valid=0 -> ins_ready=1, outs_valid=000, no state change.
- Reset mid-token: branch0 accepted (sent=001), then rst pulse for one cycle -> sent=000. After release, outs_valid=111 for the same token.
- FORK_LAZY_EN build: outs_ready=011, ins_valid=1 -> outs_valid=100, ins_ready=0. Then outs_ready=111 -> outs_valid=111, ins_ready=1.
